// File: rtl/axi_stream_strip_header.sv
// Removes a 0..DATA_BYTE_WD byte header from the front of an AXI-Stream packet,
// re-packs the payload MSB-aligned and returns the header right-aligned on a side channel.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] header_keep,
  output logic                    header_valid,
  output logic                    strip_err
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;

  typedef logic [CNT_WD-1:0]       cnt_t;
  typedef logic [DATA_WD-1:0]      word_t;
  typedef logic [DATA_BYTE_WD-1:0] keep_t;
  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  function automatic keep_t keep_top(input int n);
    keep_top = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < n) keep_top[DATA_BYTE_WD-1-i] = 1'b1;
  endfunction

  function automatic keep_t keep_low(input int n);
    keep_low = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < n) keep_low[i] = 1'b1;
  endfunction

  function automatic word_t byte_mask(input keep_t k);
    byte_mask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      byte_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  function automatic int popcount(input keep_t k);
    popcount = 0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      popcount += int'(k[i]);
  endfunction

  state_t state;
  cnt_t   n_r;        // clamped strip count of the current packet
  cnt_t   hold_cnt;   // bytes waiting in hold_data
  word_t  hold_data;  // held bytes, kept MSB-aligned and zero-filled

  logic  load;
  logic  accept;
  word_t in_masked;
  word_t body_word;
  cnt_t  n_clamped;
  int    in_len;
  int    n_i;
  int    h_i;
  int    total;

  // NOTE: every signal gets a value on every path of always_comb, otherwise a latch is inferred.
  always_comb begin
    load        = ready_out || !valid_out;
    ready_strip = rst_n && (state == IDLE);
    ready_in    = ((state == FIRST) || (state == BODY)) && load;
    accept      = valid_in && ready_in;
    in_masked   = data_in & byte_mask(keep_in);
    in_len      = popcount(keep_in);
    n_i         = int'(n_r);
    h_i         = int'(hold_cnt);
    total       = h_i + in_len;
    body_word   = hold_data | (in_masked >> (8 * h_i));
    n_clamped   = (byte_strip_cnt > cnt_t'(DATA_BYTE_WD)) ? cnt_t'(DATA_BYTE_WD) : byte_strip_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments only; the defaults at the top make the
  // side-channel flags single-cycle pulses and empty the output register whenever it may load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n_r          <= '0;
      hold_cnt     <= '0;
      hold_data    <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      header_out   <= '0;
      header_keep  <= '0;
      header_valid <= 1'b0;
      strip_err    <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      strip_err    <= 1'b0;
      if (load) begin
        valid_out <= 1'b0;
        data_out  <= '0;
        keep_out  <= '0;
        last_out  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (valid_strip) begin
            n_r   <= n_clamped;
            state <= FIRST;
          end
        end

        FIRST: begin
          if (accept) begin
            header_valid <= 1'b1;
            header_out   <= in_masked >> (8 * (DATA_BYTE_WD - n_i));
            header_keep  <= keep_low(n_i);
            hold_cnt     <= '0;
            hold_data    <= '0;
            if (last_in && (in_len <= n_i)) begin
              strip_err <= 1'b1;
              state     <= IDLE;
            end else if (n_i == 0) begin
              valid_out <= 1'b1;
              data_out  <= in_masked;
              keep_out  <= keep_in;
              last_out  <= last_in;
              state     <= last_in ? IDLE : BODY;
            end else if (n_i == DATA_BYTE_WD) begin
              state <= BODY;
            end else begin
              // Partial header: the tail of this beat starts the first payload beat.
              hold_cnt  <= cnt_t'(DATA_BYTE_WD - n_i);
              hold_data <= in_masked << (8 * n_i);
              if (last_in) begin
                valid_out <= 1'b1;
                data_out  <= in_masked << (8 * n_i);
                keep_out  <= keep_top(in_len - n_i);
                last_out  <= 1'b1;
                state     <= IDLE;
              end else begin
                state <= BODY;
              end
            end
          end
        end

        BODY: begin
          if (accept) begin
            valid_out <= 1'b1;
            hold_data <= in_masked << (8 * (DATA_BYTE_WD - h_i));
            if (!last_in) begin
              data_out <= body_word;
              keep_out <= '1;
            end else if (total <= DATA_BYTE_WD) begin
              data_out <= body_word & byte_mask(keep_top(total));
              keep_out <= keep_top(total);
              last_out <= 1'b1;
              state    <= IDLE;
            end else begin
              data_out <= body_word;
              keep_out <= '1;
              hold_cnt <= cnt_t'(total - DATA_BYTE_WD);
              state    <= FLUSH;
            end
          end
        end

        FLUSH: begin
          if (load) begin
            valid_out <= 1'b1;
            data_out  <= hold_data & byte_mask(keep_top(h_i));
            keep_out  <= keep_top(h_i);
            last_out  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed vector table, hand-written corner sequences and
// random packets scored against a byte-queue model of header stripping.
module tb_axi_stream_strip_header;

  localparam int DW = 32;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_strip;
  logic [2:0]  byte_strip_cnt;
  logic        ready_strip;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic [31:0] header_out;
  logic [3:0]  header_keep;
  logic        header_valid;
  logic        strip_err;

  axi_stream_strip_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .header_out(header_out), .header_keep(header_keep), .header_valid(header_valid),
    .strip_err(strip_err)
  );

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  typedef struct packed {logic [31:0] h; logic [3:0] k; logic e;} hdr_t;
  typedef struct packed {
    logic [3:0]       n;
    logic [1:0]       nb;
    logic [2:0][31:0] din;
    logic [3:0]       klast;
    logic [31:0]      hdr;
    logic [3:0]       hk;
    logic             err;
    logic [1:0]       no;
    logic [2:0][31:0] dout;
    logic [2:0][3:0]  kout;
  } vec_t;
  typedef logic [7:0] byte_q_t[$];

  beat_t exp_beats[$];
  hdr_t  exp_hdrs[$];
  vec_t  vecs[7];
  int    errors = 0;
  int    checks = 0;
  int    stall_viol = 0;
  int    rdy_mode = 0;
  bit    mon_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ready_out pattern: 0 always high, 1 repeating 1,0,0, 2 random (mostly high)
  initial begin
    int phase = 0;
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          ready_out = (phase == 0);
          phase = (phase + 1) % 3;
        end
        2: ready_out = ($urandom_range(0, 3) != 0);
        default: ready_out = 1'b1;
      endcase
    end
  end

  // Output monitor / scoreboard, sampled mid-cycle
  initial begin
    logic        prev_stall;
    logic [36:0] prev_out;
    beat_t       b;
    hdr_t        h;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && ({valid_out, data_out, keep_out, last_out} !== {1'b1, prev_out}))
          stall_viol++;
        prev_stall = valid_out && !ready_out;
        prev_out   = {data_out, keep_out, last_out};
        if (mon_en) begin
          if (valid_out && ready_out) begin
            if (exp_beats.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got %h expected none", {data_out, keep_out, last_out});
            end else begin
              b = exp_beats.pop_front();
              check("out_beat", 64'({data_out, keep_out, last_out}), 64'(b));
            end
          end
          if (header_valid) begin
            if (exp_hdrs.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_header: got %h expected none", {header_out, header_keep});
            end else begin
              h = exp_hdrs.pop_front();
              check("header", 64'({header_out, header_keep, strip_err}), 64'(h));
            end
          end else if (strip_err) begin
            checks++;
            errors++;
            $display("FAIL stray_strip_err: got 1 expected 0 without header_valid");
          end
        end
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic strip(input int n);
    int c = 0;
    valid_strip    = 1'b1;
    byte_strip_cnt = 3'(n);
    do begin @(negedge clk); c++; end while (!ready_strip && c < 200);
    if (!ready_strip) begin
      checks++;
      errors++;
      $display("FAIL strip_timeout: got ready_strip=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    valid_strip    = 1'b0;
    byte_strip_cnt = '0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int c = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    do begin @(negedge clk); c++; end while (!ready_in && c < 200);
    if (!ready_in) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got ready_in=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = '0;
    keep_in  = '0;
    last_in  = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_beats.size() != 0 || exp_hdrs.size() != 0) && c < 400) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drained", 64'(exp_beats.size() + exp_hdrs.size()), 64'd0);
    exp_beats.delete();
    exp_hdrs.delete();
  endtask

  function automatic vec_t mk(input int n, input int nb, input logic [31:0] d0, d1, d2,
                              input logic [3:0] kl, input logic [31:0] hdr, input logic [3:0] hk,
                              input logic err, input int no, input logic [31:0] o0, o1, o2,
                              input logic [3:0] k0, k1, k2);
    vec_t v;
    v.n = 4'(n);   v.nb = 2'(nb);
    v.din[0] = d0; v.din[1] = d1; v.din[2] = d2;
    v.klast = kl;  v.hdr = hdr; v.hk = hk; v.err = err; v.no = 2'(no);
    v.dout[0] = o0; v.dout[1] = o1; v.dout[2] = o2;
    v.kout[0] = k0; v.kout[1] = k1; v.kout[2] = k2;
    return v;
  endfunction

  task automatic push_vec(input vec_t v);
    hdr_t  h;
    beat_t b;
    h.h = v.hdr; h.k = v.hk; h.e = v.err;
    exp_hdrs.push_back(h);
    for (int i = 0; i < int'(v.no); i++) begin
      b.d = v.dout[i]; b.k = v.kout[i]; b.l = (i == int'(v.no) - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    push_vec(v);
    strip(int'(v.n));
    for (int i = 0; i < int'(v.nb); i++)
      drive_beat(v.din[i], (i == int'(v.nb) - 1) ? v.klast : 4'hF, i == int'(v.nb) - 1);
    wait_drain();
  endtask

  // Reference model: strip the first min(n,4) bytes, re-pack the rest four per beat.
  task automatic push_expect(input int n_raw, input byte_q_t pkt);
    int    n = (n_raw > 4) ? 4 : n_raw;
    int    len;
    int    nbeats;
    hdr_t  h;
    beat_t b;
    byte_q_t pay;
    h.h = '0;
    for (int i = 0; i < n; i++)
      h.h = (h.h << 8) | 32'((i < pkt.size()) ? pkt[i] : 8'h00);
    h.k = 4'((1 << n) - 1);
    h.e = (pkt.size() <= n);
    exp_hdrs.push_back(h);
    if (!h.e) begin
      for (int i = n; i < pkt.size(); i++) pay.push_back(pkt[i]);
      len = pay.size();
      nbeats = (len + 3) / 4;
      for (int bi = 0; bi < nbeats; bi++) begin
        b.d = '0; b.k = '0; b.l = (bi == nbeats - 1);
        for (int j = 0; j < 4; j++)
          if (bi * 4 + j < len) begin
            b.d[31-8*j -: 8] = pay[bi*4+j];
            b.k[3-j] = 1'b1;
          end
        exp_beats.push_back(b);
      end
    end
  endtask

  task automatic send_pkt(input int n, input byte_q_t pkt);
    int nb = (pkt.size() + 3) / 4;
    logic [31:0] d;
    logic [3:0]  k;
    strip(n);
    for (int bi = 0; bi < nb; bi++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++)
        if (bi * 4 + j < pkt.size()) begin
          d[31-8*j -: 8] = pkt[bi*4+j];
          k[3-j] = 1'b1;
        end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      drive_beat(d, k, bi == nb - 1);
    end
  endtask

  initial begin
    byte_q_t pkt;
    int n;
    int len;
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_strip = 1'b0; byte_strip_cnt = '0;

    vecs[0] = mk(1, 3, 32'hA1B2C3D4, 32'h11223344, 32'h55667788, 4'hC, 32'h000000A1, 4'h1, 1'b0,
                 3, 32'hB2C3D411, 32'h22334455, 32'h66000000, 4'hF, 4'hF, 4'h8);
    vecs[1] = mk(3, 2, 32'hA1B2C3D4, 32'h11223344, 32'h0, 4'hF, 32'h00A1B2C3, 4'h7, 1'b0,
                 2, 32'hD4112233, 32'h44000000, 32'h0, 4'hF, 4'h8, 4'h0);
    vecs[2] = mk(0, 3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 4'hE, 32'h0, 4'h0, 1'b0,
                 3, 32'h01020304, 32'h05060708, 32'h090A0B00, 4'hF, 4'hF, 4'hE);
    vecs[3] = mk(4, 3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 4'hE, 32'h01020304, 4'hF, 1'b0,
                 2, 32'h05060708, 32'h090A0B00, 32'h0, 4'hF, 4'hE, 4'h0);
    vecs[4] = mk(2, 1, 32'hAABBCCDD, 32'h0, 32'h0, 4'hC, 32'h0000AABB, 4'h3, 1'b1,
                 0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    vecs[5] = mk(5, 2, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 4'h8, 32'hDEADBEEF, 4'hF, 1'b0,
                 1, 32'hCA000000, 32'h0, 32'h0, 4'h8, 4'h0, 4'h0);
    vecs[6] = mk(2, 1, 32'h12345678, 32'h0, 32'h0, 4'hF, 32'h00001234, 4'h3, 1'b0,
                 1, 32'h56780000, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_out_regs", 64'({data_out, keep_out, last_out}), 64'd0);
    check("rst_header", 64'({header_out, header_keep, header_valid, strip_err}), 64'd0);
    check("rst_ready", 64'({ready_in, ready_strip}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'({ready_in, ready_strip}), 64'b01);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // N=0 pass-through appears one cycle after acceptance
    push_vec(vecs[2]);
    strip(0);
    drive_beat(32'h01020304, 4'hF, 1'b0);
    @(negedge clk);
    check("latency_valid", 64'(valid_out), 64'd1);
    check("latency_data", 64'(data_out), 64'h01020304);
    @(posedge clk);
    #1;
    drive_beat(32'h05060708, 4'hF, 1'b0);
    drive_beat(32'h090A0B0C, 4'hE, 1'b1);
    wait_drain();

    // Header swallows the whole packet
    push_vec(vecs[4]);
    strip(2);
    drive_beat(32'hAABBCCDD, 4'hC, 1'b1);
    @(negedge clk);
    check("err_pulse", 64'({strip_err, ready_strip, valid_out}), 64'b110);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure 1,0,0 pattern
    rdy_mode = 1;
    stall_viol = 0;
    apply_vec(vecs[0]);
    apply_vec(vecs[1]);
    check("stall_stable", 64'(stall_viol), 64'd0);
    rdy_mode = 0;

    // Reset in the middle of a packet
    mon_en = 1'b0;
    strip(1);
    drive_beat(32'hA1B2C3D4, 4'hF, 1'b0);
    drive_beat(32'h11223344, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_out_regs", 64'({data_out, keep_out, last_out}), 64'd0);
    check("midrst_header", 64'({header_out, header_keep, header_valid, strip_err}), 64'd0);
    check("midrst_ready", 64'({ready_in, ready_strip}), 64'd0);
    exp_beats.delete();
    exp_hdrs.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    apply_vec(vecs[0]);

    // Random packets back to back under random backpressure
    rdy_mode = 2;
    stall_viol = 0;
    for (int p = 0; p < 40; p++) begin
      n = int'($urandom_range(0, 6));
      len = int'($urandom_range(1, 13));
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      push_expect(n, pkt);
      send_pkt(n, pkt);
    end
    wait_drain();
    check("rand_stall_stable", 64'(stall_viol), 64'd0);
    rdy_mode = 0;

    finish_run();
  end

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Receive-side counterpart of the header-insert path: removes a per-packet header of 0..DATA_BYTE_WD bytes from the front of an AXI-Stream packet.
- Realigns the remaining payload so that every output beat is MSB-aligned.
- Returns the stripped header bytes on a side channel. The side-channel format (right-aligned header, right-aligned header keep) matches the insert side's header format.
- Sits at the downstream end of a link, after the inserted-header stream.

Parameters:
- DATA_WD, 32: stream data width in bits.
- DATA_BYTE_WD, DATA_WD/8: bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD): width of a byte count; strip counts use BYTE_CNT_WD+1 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data; stream byte 0 = data_in[DATA_WD-1 -: 8].
- keep_in  in  DATA_BYTE_WD  all ones except on the last beat, which is MSB-aligned (1111/1110/1100/1000).
- last_in  in  1  last beat of packet.
- ready_in  out  1  input accept.
- valid_strip  in  1  strip count valid for the next packet.
- byte_strip_cnt  in  BYTE_CNT_WD+1  header bytes to remove, N = 0..DATA_BYTE_WD.
- ready_strip  out  1  strip count accept.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  realigned payload; invalid bytes driven 0.
- keep_out  out  DATA_BYTE_WD  MSB-aligned byte enables.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream accept.
- header_out  out  DATA_WD  stripped header bytes, right-aligned, upper bytes 0.
- header_keep  out  DATA_BYTE_WD  (1<<N)-1.
- header_valid  out  1  one-cycle pulse when the header is captured.
- strip_err  out  1  one-cycle pulse when a packet has no payload left after stripping.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, hold register cleared. A reset mid-packet discards all state; the next packet requires a new strip handshake.
- FSM states: IDLE, FIRST, BODY, FLUSH.
- IDLE:
  - ready_strip=1, ready_in=0.
  - On valid_strip: latch N and S = N mod DATA_BYTE_WD, then go to FIRST.
  - N > DATA_BYTE_WD is clamped to DATA_BYTE_WD.
- Output register:
  - valid_out/data_out/keep_out/last_out are registered.
  - They are held stable while valid_out && !ready_out.
  - ready_in (FIRST/BODY) = ready_out || !valid_out. This is the "can load" condition, called load below.
- FIRST (first input beat accepted):
  - header_out = top N bytes of the beat, right-aligned; header_keep = (1<<N)-1; header_valid pulses the cycle after acceptance.
  - With N=0 the pulse still fires, with header_keep=0.
  - Let L = number of ones in keep_in.
  - If last_in and L <= N: no output beat, strip_err pulse, go to IDLE.
  - If S=0, N=0: the beat passes through unchanged to the output (next cycle).
  - If S=0, N=DATA_BYTE_WD: the beat is dropped.
  - If S>0: the low DATA_BYTE_WD-S bytes go to the hold register (hold_cnt = DATA_BYTE_WD-S); no output beat.
  - If last_in and L > N, with S>0: emit {remaining L-N bytes, zero fill}, keep = top (L-N) ones, last_out=1, go to IDLE.
  - If last_in and L > N, with S=0 and N=0: the passed beat itself is emitted with last_out=1, go to IDLE.
  - Otherwise go to BODY.
- BODY, per accepted beat with hold_cnt = H:
  - out = {hold[top H bytes], in[top DATA_BYTE_WD-H bytes]}.
  - New hold = low H bytes of in.
  - When H=0 this reduces to pass-through.
- Last beat in BODY (L valid bytes):
  - T = H+L.
  - If T <= DATA_BYTE_WD: emit keep = top T ones, last_out=1, go to IDLE.
  - Else: emit a full beat, hold T-DATA_BYTE_WD bytes, go to FLUSH. ready_in=0 in FLUSH.
- FLUSH: when load, emit hold bytes MSB-aligned, keep = top (T-DATA_BYTE_WD) ones, last_out=1, go to IDLE.
- Latency: one cycle from the completing input beat to valid_out. Sustained throughput is 1 beat/cycle while ready_out=1.
- Backpressure: while ready_out=0 and valid_out=1, ready_in=0 and no state advances.
- valid_strip while not in IDLE is ignored (ready_strip=0).
- The next packet's strip handshake may occur in the same cycle the previous last beat leaves the output register.

Test Plan:
1. N=1, beats 0xA1B2C3D4, 0x11223344, last 0x55667788 keep 1100, ready_out=1 -> header_out 0x000000A1, keep 0001; out 0xB2C3D411/1111, 0x22334455/1111, 0x66000000/1000 last.
2. N=3, beats 0xA1B2C3D4, last 0x11223344 keep 1111 -> header 0x00A1B2C3/0111; out 0xD4112233/1111, 0x44000000/1000 last.
3. N=0, 3-beat packet (last keep 1110) -> header_keep 0000 with header_valid pulse; output identical to input, 1-cycle latency; N=4 same packet -> header 1st beat/1111, out = beats 2..3 unchanged.
4. N=2, single beat 0xAABBCCDD keep 1100, last -> strip_err pulse, no valid_out, ready_strip back to 1 next cycle.
5. Scenario 1 with ready_out toggling 1,0,0,1,... -> data_out/keep_out stable while stalled; byte sequence identical to scenario 1; no beat lost or duplicated.
6. rst_n low while in BODY -> all outputs 0 immediately; next packet with N=1 reproduces scenario 1 exactly.
